// File: rtl/hazard_unit.sv
// Load-use / branch-operand interlock for the 5-stage MIPS pipeline.
// Drives PC and IF/ID enables, the ID/EX bubble, the gated flush and a stall counter.
module hazard_unit #(
    parameter int REG_W = 5,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_uses_rt,
    input  logic             hazard_en,
    input  logic             cond_hazard,
    input  logic             IF_flush,
    input  logic             ex_reg_write,
    input  logic             ex_mem_read,
    input  logic [REG_W-1:0] ex_rd,
    input  logic             mem_mem_read,
    input  logic [REG_W-1:0] mem_rd,
    input  logic             stall_clr,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             id_ex_bubble,
    output logic             if_id_flush,
    output logic [CNT_W-1:0] stall_count
);

    typedef enum logic {RUN, HOLD} state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ex_match, mem_match;
    logic             h1, h2, stall;

    assign ex_match  = (ex_rd != '0) &&
                       ((ex_rd == id_rs) || (id_uses_rt && (ex_rd == id_rt)));
    assign mem_match = (mem_rd != '0) &&
                       ((mem_rd == id_rs) || (id_uses_rt && (mem_rd == id_rt)));

    // Branches resolve in ID, so a load feeding one needs an extra cycle.
    assign h2 = hazard_en && cond_hazard && ex_mem_read && ex_match;
    assign h1 = hazard_en && (
                    (!cond_hazard && ex_mem_read && ex_match) ||
                    (cond_hazard && ex_reg_write && !ex_mem_read && ex_match) ||
                    (cond_hazard && mem_mem_read && mem_match));

    always_comb begin
        state_d = state_q;
        stall   = 1'b0;
        if (state_q == HOLD) begin
            stall   = 1'b1;
            state_d = RUN;
        end else if (h2) begin
            stall   = 1'b1;
            state_d = HOLD;
        end else if (h1) begin
            stall   = 1'b1;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (stall_clr) begin
            cnt_d = '0;
        end else if (stall && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Outputs are held in the safe (frozen, bubbling) state during reset.
    assign pc_write     = rst_n & ~stall;
    assign if_id_write  = rst_n & ~stall;
    assign id_ex_bubble = ~rst_n | stall;
    assign if_id_flush  = rst_n & IF_flush & ~stall;
    assign stall_count  = cnt_q;

endmodule

// File: doc/hazard_unit.md
Name: hazard_unit

Overview:
- Pipeline interlock unit for the 5-stage MIPS core; sits beside the ID-stage decoder and consumes its hazard_en / cond_hazard / IF_flush outputs.
- Compares ID source registers against EX and MEM destinations and produces PC/IF-ID write enables, an ID/EX bubble and a gated IF/ID flush.
- Holds a small stall-sequencing FSM for two-cycle load-to-branch interlocks, plus a saturating stall-cycle performance counter.

Parameters:
- REG_W, 5, register-specifier width.
- CNT_W, 16, stall counter width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  synchronous active-low reset.
- id_rs  in  REG_W  ID rs field.
- id_rt  in  REG_W  ID rt field.
- id_uses_rt  in  1  ID instruction reads rt (R-type, sw, beq, bne).
- hazard_en  in  1  ID instruction reads registers; interlock check enabled.
- cond_hazard  in  1  ID instruction resolves in ID (beq, bne, jr); operands are needed in ID.
- IF_flush  in  1  taken branch/jump request from decoder.
- ex_reg_write  in  1  EX instruction writes a register.
- ex_mem_read  in  1  EX instruction is lw.
- ex_rd  in  REG_W  EX destination (after reg_dst/Ch_31 mux).
- mem_mem_read  in  1  MEM instruction is lw.
- mem_rd  in  REG_W  MEM destination.
- stall_clr  in  1  synchronous clear of stall_count.
- pc_write  out  1  PC load enable.
- if_id_write  out  1  IF/ID register load enable.
- id_ex_bubble  out  1  zero the control fields entering ID/EX.
- if_id_flush  out  1  clear IF/ID (squash fetched instruction).
- stall_count  out  CNT_W  saturating count of stall cycles.

Behaviour:
- match(d) = (d != 0) & ((d == id_rs) | (id_uses_rt & d == id_rt)). Register 0 never causes a hazard.
- Hazard classes are evaluated combinationally in state RUN, and only when hazard_en=1:
  - H2 (needs 2 stalls): cond_hazard & ex_mem_read & match(ex_rd).
  - H1 (needs 1 stall), any of:
    - ~cond_hazard & ex_mem_read & match(ex_rd).
    - cond_hazard & ex_reg_write & ~ex_mem_read & match(ex_rd).
    - cond_hazard & mem_mem_read & match(mem_rd).
  - H2 has priority over H1.
- FSM states: RUN, HOLD.
  - RUN & H2: stall=1; next state HOLD.
  - RUN & H1: stall=1; stay in RUN and re-evaluate next cycle. The pipeline has advanced, so the hazard clears.
  - RUN, no hazard: stall=0.
  - HOLD: stall=1 unconditionally, no re-evaluation; next state RUN.
- Outputs from stall:
  - pc_write = if_id_write = ~stall.
  - id_ex_bubble = stall.
  - if_id_flush = IF_flush & ~stall. A branch decision made on stale operands is ignored; the flush recurs once operands are valid.
- Reset (rst_n=0 at an edge): state goes to RUN and stall_count to 0, including from HOLD mid-sequence.
- While rst_n=0, outputs are forced: pc_write=0, if_id_write=0, id_ex_bubble=1, if_id_flush=0.
- stall_count per cycle:
  - If stall_clr, load 0.
  - Else if stall=1 and count != all-ones, increment by 1.
  - Saturates at 2^CNT_W-1 and never wraps.
  - stall_clr has priority over increment in the same cycle.
- Latency: interlock outputs are combinational from inputs and state; no added pipeline delay. Only state and stall_count are registered.

Test Plan:
- lw r2 in EX (ex_mem_read=1, ex_rd=2), ID add reading rs=2, hazard_en=1, cond_hazard=0 -> one cycle with pc_write=0, id_ex_bubble=1; next cycle (EX bubble, ex_mem_read=0) stall=0; stall_count=1.
- lw r3 in EX, ID beq rs=3, cond_hazard=1, IF_flush=1 -> two consecutive stall cycles (RUN→HOLD→RUN); if_id_flush=0 during both; third cycle if_id_flush=1; stall_count=2.
- ex_rd=0 with ex_mem_read=1 and id_rs=0 -> no stall; pc_write=1 every cycle.
- rst_n=0 asserted while in HOLD -> next edge state RUN, stall_count=0; during reset pc_write=0, id_ex_bubble=1, if_id_flush=0.
- CNT_W=4, hold a hazard for 20 stall cycles -> stall_count saturates at 15; stall_clr=1 together with stall=1 -> stall_count=0 next cycle.
- id_uses_rt=0, ex_mem_read=1, ex_rd=id_rt=5, id_rs=6 -> no stall; with id_uses_rt=1 -> one stall cycle.
